// File: rtl/clink_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clink_uart_pkg
// Description : Shared types and constants for the CameraLink serial-control
//               UART: parity modes, TX/RX state encodings and the oversample
//               rate. Also holds the cfg_parity decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clink_uart_pkg;

  // Oversample ticks per bit, and the tick inside a bit where RX samples
  localparam int OS_RATE     = 16;
  localparam int SAMPLE_TICK = 7;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP1  = 3'd4,
    TX_STOP2  = 3'd5
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  // cfg_parity encoding 2'b11 is reserved and behaves as "no parity"
  function automatic parity_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_ODD;
      2'b10:   return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/clink_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : clink_uart_if
// Description : Register-side bus of the CameraLink UART plus the serial
//               pair. The master modport is the AXI register slave (and the
//               camera-side driver of rxd); the slave modport is the UART.
//   cfg_*        : divisor / parity / stop-bit configuration
//   tx_*         : TX push handshake and FIFO status
//   rx_*         : RX byte handshake and sticky error flags
//   err_clr      : clears sticky RX errors
//   txd / rxd    : serial out (SerTFG) / serial in (SerTC, asynchronous)
// Revision    : 1.0 - initial release
// ============================================================================
interface clink_uart_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int LVL_W  = 5
);
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_div_load;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_busy;
  logic [LVL_W-1:0]  tx_level;
  logic              txd;
  logic              rxd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic              rx_frame_err;
  logic              rx_parity_err;
  logic              err_clr;

  modport master (
    output cfg_div, cfg_div_load, cfg_parity, cfg_stop2,
    output tx_data, tx_valid, rx_ready, err_clr, rxd,
    input  tx_ready, tx_busy, tx_level, txd,
    input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  cfg_div, cfg_div_load, cfg_parity, cfg_stop2,
    input  tx_data, tx_valid, rx_ready, err_clr, rxd,
    output tx_ready, tx_busy, tx_level, txd,
    output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err
  );
endinterface
`default_nettype wire

// File: rtl/clink_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : clink_uart_fifo
// Description : Synchronous first-word-fall-through FIFO.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_data : write request / data (ignored while full)
//   i_pop          : read request (ignored while empty)
//   o_data         : head entry, valid while !o_empty
//   o_full, o_empty, o_level : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module clink_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/clink_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clink_uart_ctrl
// Description : Full-duplex UART for the CameraLink serial control channel.
//               Shared 16x oversample tick, TX FIFO + TX framer with runtime
//               parity / stop-bit selection, 16x oversampled receiver with
//               single-entry output register and sticky error flags.
//   s_axi_aclk    : sole clock
//   s_axi_aresetn : synchronous active-low reset
//   bus           : clink_uart_if slave modport (config, TX, RX, serial pins)
// Revision    : 1.0 - initial release
// ============================================================================
module clink_uart_ctrl
  import clink_uart_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int DIV_W         = 16,
  parameter int DIV_DEFAULT   = 651
) (
  input  logic         s_axi_aclk,
  input  logic         s_axi_aresetn,
  clink_uart_if.slave  bus
);
  localparam int LVL_W = $clog2(TX_FIFO_DEPTH) + 1;
  localparam int BIT_W = $clog2(DATA_W);

  // --------------------------------------------------------------------------
  // Oversample tick generator
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_last;
  logic             w_os_tick;

  // A divisor of zero behaves as one: tick every clock
  assign w_div_last = (r_div == '0) ? '0 : (r_div - DIV_W'(1));
  assign w_os_tick  = !bus.cfg_div_load && (r_div_cnt == w_div_last);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_div     <= DIV_W'(DIV_DEFAULT);
      r_div_cnt <= '0;
    end else if (bus.cfg_div_load) begin
      r_div     <= bus.cfg_div;
      r_div_cnt <= '0;
    end else if (w_os_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_fifo_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [LVL_W-1:0]  w_fifo_level;
  logic              w_tx_load;

  clink_uart_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_tx_fifo (
    .i_clk   (s_axi_aclk),
    .i_rst_n (s_axi_aresetn),
    .i_push  (bus.tx_valid),
    .i_data  (bus.tx_data),
    .i_pop   (w_tx_load),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // --------------------------------------------------------------------------
  // TX framer
  // --------------------------------------------------------------------------
  tx_state_e         r_tx_state;
  tx_state_e         w_tx_state_nxt;
  logic [3:0]        r_tx_os;
  logic [BIT_W-1:0]  r_tx_bit;
  logic [DATA_W-1:0] r_tx_sh;
  logic              r_tx_par_bit;
  logic              r_tx_par_en;
  logic              r_tx_stop2;
  logic              r_txd;
  logic              w_txd;
  logic              w_tx_busy;
  logic              w_tx_bit_end;
  parity_e           w_tx_par_mode;

  assign w_tx_bit_end  = w_os_tick && (r_tx_os == 4'(OS_RATE - 1));
  assign w_tx_par_mode = decode_parity(bus.cfg_parity);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) r_tx_state <= TX_IDLE;
    else                r_tx_state <= w_tx_state_nxt;
  end

  // After the last stop bit a waiting byte goes straight to START so that
  // consecutive frames have no idle gap.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE:   if (w_os_tick && !w_fifo_empty) w_tx_state_nxt = TX_START;
      TX_START:  if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
      TX_DATA:   if (w_tx_bit_end && (r_tx_bit == BIT_W'(DATA_W - 1)))
                   w_tx_state_nxt = r_tx_par_en ? TX_PARITY : TX_STOP1;
      TX_PARITY: if (w_tx_bit_end) w_tx_state_nxt = TX_STOP1;
      TX_STOP1:  if (w_tx_bit_end)
                   w_tx_state_nxt = r_tx_stop2   ? TX_STOP2 :
                                    w_fifo_empty ? TX_IDLE  : TX_START;
      TX_STOP2:  if (w_tx_bit_end)
                   w_tx_state_nxt = w_fifo_empty ? TX_IDLE : TX_START;
      default:   w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_txd     = 1'b1;
    w_tx_load = (w_tx_state_nxt == TX_START) && (r_tx_state != TX_START);
    w_tx_busy = !w_fifo_empty || (r_tx_state != TX_IDLE);
    case (r_tx_state)
      TX_START:  w_txd = 1'b0;
      TX_DATA:   w_txd = r_tx_sh[0];
      TX_PARITY: w_txd = r_tx_par_bit;
      default:   w_txd = 1'b1;
    endcase
  end

  // Frame options are captured with the byte so mid-frame config writes
  // only affect the next frame.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_tx_os      <= '0;
      r_tx_bit     <= '0;
      r_tx_sh      <= '0;
      r_tx_par_bit <= 1'b0;
      r_tx_par_en  <= 1'b0;
      r_tx_stop2   <= 1'b0;
      r_txd        <= 1'b1;
    end else begin
      r_txd <= w_txd;
      if (w_tx_load) begin
        r_tx_os      <= '0;
        r_tx_bit     <= '0;
        r_tx_sh      <= w_fifo_data;
        r_tx_par_en  <= (w_tx_par_mode != PAR_NONE);
        r_tx_par_bit <= (w_tx_par_mode == PAR_ODD) ? ~^w_fifo_data : ^w_fifo_data;
        r_tx_stop2   <= bus.cfg_stop2;
      end else if (w_os_tick && (r_tx_state != TX_IDLE)) begin
        r_tx_os <= r_tx_os + 4'd1;
        if ((r_tx_state == TX_DATA) && (r_tx_os == 4'(OS_RATE - 1))) begin
          r_tx_sh  <= r_tx_sh >> 1;
          r_tx_bit <= r_tx_bit + BIT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // RX synchroniser and receiver
  // --------------------------------------------------------------------------
  logic              r_rx_meta;
  logic              r_rx_sync;
  logic              r_rx_prev;
  logic              w_rxd;
  logic              w_rx_fall;

  assign w_rxd     = r_rx_sync;
  assign w_rx_fall = r_rx_prev && !r_rx_sync;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rxd;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  rx_state_e         r_rx_state;
  rx_state_e         w_rx_state_nxt;
  logic [3:0]        r_rx_os;
  logic [BIT_W-1:0]  r_rx_bit;
  logic [DATA_W-1:0] r_rx_sh;
  logic              r_rx_par_en;
  logic              r_rx_odd;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_overrun;
  logic              r_rx_frame_err;
  logic              r_rx_parity_err;
  logic              w_rx_sample;
  logic              w_rx_shift;
  logic              w_rx_done;
  logic              w_rx_par_bad;
  logic              w_rx_frame_bad;
  logic              w_rx_ovr_evt;
  parity_e           w_rx_par_mode;

  // The bit counter is zeroed on the falling edge, so tick 7 lands near the
  // centre of START and every later sample is one full bit further on.
  assign w_rx_sample   = w_os_tick && (r_rx_os == 4'(SAMPLE_TICK));
  assign w_rx_par_mode = decode_parity(bus.cfg_parity);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) r_rx_state <= RX_IDLE;
    else                r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:      if (w_rx_fall) w_rx_state_nxt = RX_START;
      RX_START:     if (w_rx_sample) w_rx_state_nxt = w_rxd ? RX_IDLE : RX_DATA;
      RX_DATA:      if (w_rx_sample && (r_rx_bit == BIT_W'(DATA_W - 1)))
                      w_rx_state_nxt = r_rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (w_rx_sample) w_rx_state_nxt = RX_STOP;
      RX_STOP:      if (w_rx_sample) w_rx_state_nxt = w_rxd ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (w_rxd) w_rx_state_nxt = RX_IDLE;
      default:      w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_shift     = (r_rx_state == RX_DATA) && w_rx_sample;
    w_rx_done      = (r_rx_state == RX_STOP) && w_rx_sample;
    w_rx_par_bad   = (r_rx_state == RX_PARITY) && w_rx_sample &&
                     (w_rxd != (r_rx_odd ? ~^r_rx_sh : ^r_rx_sh));
    w_rx_frame_bad = w_rx_done && !w_rxd;
    w_rx_ovr_evt   = w_rx_done && r_rx_valid && !bus.rx_ready;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_rx_os     <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_rx_par_en <= 1'b0;
      r_rx_odd    <= 1'b0;
    end else begin
      if (r_rx_state == RX_IDLE) begin
        if (w_rx_fall) begin
          r_rx_os     <= '0;
          r_rx_bit    <= '0;
          r_rx_par_en <= (w_rx_par_mode != PAR_NONE);
          r_rx_odd    <= (w_rx_par_mode == PAR_ODD);
        end
      end else if (w_os_tick) begin
        r_rx_os <= r_rx_os + 4'd1;
      end
      if (w_rx_shift) begin
        r_rx_sh  <= {w_rxd, r_rx_sh[DATA_W-1:1]};
        r_rx_bit <= r_rx_bit + BIT_W'(1);
      end
    end
  end

  // Output register: a byte arriving while the previous one is unclaimed is
  // dropped; a consume in the same cycle frees the slot for it.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_overrun    <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_parity_err <= 1'b0;
    end else begin
      if (w_rx_done && (!r_rx_valid || bus.rx_ready)) begin
        r_rx_data  <= r_rx_sh;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      // Error events take priority over a simultaneous clear
      if (w_rx_ovr_evt)     r_rx_overrun    <= 1'b1;
      else if (bus.err_clr) r_rx_overrun    <= 1'b0;
      if (w_rx_frame_bad)   r_rx_frame_err  <= 1'b1;
      else if (bus.err_clr) r_rx_frame_err  <= 1'b0;
      if (w_rx_par_bad)     r_rx_parity_err <= 1'b1;
      else if (bus.err_clr) r_rx_parity_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Bus outputs
  // --------------------------------------------------------------------------
  assign bus.tx_ready      = !w_fifo_full;
  assign bus.tx_busy       = w_tx_busy;
  assign bus.tx_level      = w_fifo_level;
  assign bus.txd           = r_txd;
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_overrun    = r_rx_overrun;
  assign bus.rx_frame_err  = r_rx_frame_err;
  assign bus.rx_parity_err = r_rx_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_clink_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clink_uart_ctrl
// Description : Directed self-checking bench for clink_uart_ctrl: reset
//               state, default bit time, TX framing with parity/stop options,
//               FIFO fill and wrap, loopback RX, glitch rejection, RX error
//               flags, overrun and reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clink_uart_ctrl;
  localparam int DW       = 8;
  localparam int DEPTH    = 16;
  localparam int DIV_W    = 16;
  localparam int LVL_W    = 5;
  localparam int DIV_FAST = 4;
  localparam int T        = 16 * DIV_FAST;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  clink_uart_if #(.DATA_W(DW), .DIV_W(DIV_W), .LVL_W(LVL_W)) u_if ();

  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  assign u_if.rxd = loop_en ? u_if.txd : rxd_drv;

  clink_uart_ctrl #(
    .DATA_W        (DW),
    .TX_FIFO_DEPTH (DEPTH),
    .DIV_W         (DIV_W),
    .DIV_DEFAULT   (651)
  ) u_dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rstn),
    .bus           (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    u_if.tx_data  = b;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
  endtask

  task automatic load_div(input logic [15:0] d);
    u_if.cfg_div      = d;
    u_if.cfg_div_load = 1'b1;
    @(negedge clk);
    u_if.cfg_div_load = 1'b0;
  endtask

  task automatic wait_txd(input logic v, input int bound, output bit ok);
    int n = 0;
    while (u_if.txd !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = (u_if.txd === v);
  endtask

  task automatic run_len(input logic v, output int cnt);
    cnt = 0;
    while (u_if.txd === v && cnt < 30000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic cap_frame(input int nbits, output logic [15:0] bits);
    bit ok;
    bits = '0;
    wait_txd(1'b0, 3000, ok);
    chk("tx_start_seen", 32'(ok), 1);
    repeat (T / 2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (T) @(negedge clk);
      bits[i] = u_if.txd;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (u_if.tx_busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle_reached", 32'(u_if.tx_busy), 0);
  endtask

  task automatic wait_rx();
    int n = 0;
    while (u_if.rx_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_valid_seen", 32'(u_if.rx_valid), 1);
  endtask

  task automatic consume();
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    u_if.err_clr = 1'b1;
    @(negedge clk);
    u_if.err_clr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input bit par_en, input bit par_bit,
                         input bit stop_bit);
    rxd_drv = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (T) @(negedge clk);
    end
    if (par_en) begin
      rxd_drv = par_bit;
      repeat (T) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (T) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (T) @(negedge clk);
  endtask

  function automatic logic [2:0] err_flags();
    return {u_if.rx_overrun, u_if.rx_frame_err, u_if.rx_parity_err};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    logic [7:0]  fifo_exp [DEPTH];
    logic [7:0]  lb_bytes [3];
    bit          ok;
    int          len;

    u_if.cfg_div      = '0;
    u_if.cfg_div_load = 1'b0;
    u_if.cfg_parity   = 2'b00;
    u_if.cfg_stop2    = 1'b0;
    u_if.tx_data      = '0;
    u_if.tx_valid     = 1'b0;
    u_if.rx_ready     = 1'b0;
    u_if.err_clr      = 1'b0;
    cyc(3);
    rstn = 1'b1;
    cyc(1);

    // Reset state
    chk("rst_txd",      32'(u_if.txd), 1);
    chk("rst_tx_ready", 32'(u_if.tx_ready), 1);
    chk("rst_tx_busy",  32'(u_if.tx_busy), 0);
    chk("rst_tx_level", 32'(u_if.tx_level), 0);
    chk("rst_rx_valid", 32'(u_if.rx_valid), 0);
    chk("rst_rx_data",  32'(u_if.rx_data), 0);
    chk("rst_err",      32'(err_flags()), 0);

    // Default divisor: start bit of 0x01 lasts 16*651 clocks
    push(8'h01);
    chk("dflt_level", 32'(u_if.tx_level), 1);
    chk("dflt_busy",  32'(u_if.tx_busy), 1);
    wait_txd(1'b0, 2000, ok);
    chk("dflt_start_seen", 32'(ok), 1);
    run_len(1'b0, len);
    chk("dflt_start_len", 32'(len), 10416);
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(1);
    load_div(16'(DIV_FAST));

    // 8N1 0x48
    push(8'h48);
    cap_frame(10, bits);
    chk("8n1_frame", 32'(bits[9:0]), 32'({1'b1, 8'h48, 1'b0}));
    chk("8n1_busy_in_stop", 32'(u_if.tx_busy), 1);
    cyc(T);
    chk("8n1_busy_after", 32'(u_if.tx_busy), 0);
    chk("8n1_txd_after",  32'(u_if.txd), 1);

    // Even parity: two ones -> parity 0; odd -> parity 1
    u_if.cfg_parity = 2'b10;
    push(8'h48);
    cap_frame(11, bits);
    chk("even_frame", 32'(bits[10:0]), 32'({1'b1, 1'b0, 8'h48, 1'b0}));
    wait_idle(2000);
    u_if.cfg_parity = 2'b01;
    push(8'h48);
    cap_frame(11, bits);
    chk("odd_frame", 32'(bits[10:0]), 32'({1'b1, 1'b1, 8'h48, 1'b0}));
    wait_idle(2000);

    // Two stop bits between back-to-back frames of 0x00
    u_if.cfg_parity = 2'b00;
    u_if.cfg_stop2  = 1'b1;
    push(8'h00);
    push(8'h00);
    wait_txd(1'b0, 2000, ok);
    chk("stop2_start_seen", 32'(ok), 1);
    run_len(1'b0, len);
    chk("stop2_low_len", 32'(len), 9 * T);
    run_len(1'b1, len);
    chk("stop2_high_len", 32'(len), 2 * T);
    wait_idle(3000);
    u_if.cfg_stop2 = 1'b0;

    // FIFO fill with the tick stalled, 17th push dropped, then drain in order
    load_div(16'hFFFF);
    for (int i = 0; i < DEPTH; i++) begin
      fifo_exp[i] = 8'(16 + i * 13);
      push(fifo_exp[i]);
    end
    chk("fill_level", 32'(u_if.tx_level), 16);
    chk("fill_ready", 32'(u_if.tx_ready), 0);
    push(8'hEE);
    chk("fill_level_17", 32'(u_if.tx_level), 16);
    load_div(16'(DIV_FAST));
    for (int i = 0; i < DEPTH; i++) begin
      cap_frame(10, bits);
      chk($sformatf("fifo_frame_%0d", i), 32'(bits[9:0]), 32'({1'b1, fifo_exp[i], 1'b0}));
    end
    wait_idle(2 * T);
    chk("drain_level", 32'(u_if.tx_level), 0);

    // Loopback, last byte with even parity
    loop_en = 1'b1;
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) u_if.cfg_parity = 2'b10;
      push(lb_bytes[i]);
      wait_rx();
      chk($sformatf("lb_data_%0d", i), 32'(u_if.rx_data), 32'(lb_bytes[i]));
      chk($sformatf("lb_err_%0d", i), 32'(err_flags()), 0);
      consume();
    end
    wait_idle(2000);
    u_if.cfg_parity = 2'b00;
    loop_en = 1'b0;
    cyc(T);

    // Three-tick glitch is a false start
    rxd_drv = 1'b0;
    cyc(3 * DIV_FAST);
    rxd_drv = 1'b1;
    cyc(300);
    chk("glitch_valid", 32'(u_if.rx_valid), 0);
    chk("glitch_err",   32'(err_flags()), 0);

    // Frame error: stop bit 0, byte still delivered
    send_rx(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("fe_valid", 32'(u_if.rx_valid), 1);
    chk("fe_data",  32'(u_if.rx_data), 32'h3C);
    chk("fe_flags", 32'(err_flags()), 3'b010);
    pulse_clr();
    chk("fe_clr", 32'(err_flags()), 0);
    consume();
    chk("fe_consumed", 32'(u_if.rx_valid), 0);

    // Parity error: even parity expects 0 for 0x3C, send 1
    u_if.cfg_parity = 2'b10;
    send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
    chk("pe_data",  32'(u_if.rx_data), 32'h3C);
    chk("pe_flags", 32'(err_flags()), 3'b001);
    consume();
    pulse_clr();
    chk("pe_clr", 32'(err_flags()), 0);
    u_if.cfg_parity = 2'b00;

    // Overrun: second byte dropped while first is unclaimed
    send_rx(8'h11, 1'b0, 1'b0, 1'b1);
    send_rx(8'h22, 1'b0, 1'b0, 1'b1);
    chk("ovr_valid", 32'(u_if.rx_valid), 1);
    chk("ovr_data",  32'(u_if.rx_data), 32'h11);
    chk("ovr_flags", 32'(err_flags()), 3'b100);

    // Reset in the middle of data bit 0 of a 0x00 frame
    push(8'h00);
    push(8'h00);
    wait_txd(1'b0, 2000, ok);
    chk("mid_start_seen", 32'(ok), 1);
    cyc(T + T / 2);
    chk("mid_txd_low", 32'(u_if.txd), 0);
    rstn = 1'b0;
    cyc(1);
    chk("mid_rst_txd",   32'(u_if.txd), 1);
    chk("mid_rst_level", 32'(u_if.tx_level), 0);
    chk("mid_rst_valid", 32'(u_if.rx_valid), 0);
    chk("mid_rst_err",   32'(err_flags()), 0);
    chk("mid_rst_busy",  32'(u_if.tx_busy), 0);
    rstn = 1'b1;
    cyc(2);
    load_div(16'(DIV_FAST));
    loop_en = 1'b1;
    push(8'h5A);
    wait_rx();
    chk("post_rst_data", 32'(u_if.rx_data), 32'h5A);
    chk("post_rst_err",  32'(err_flags()), 0);
    consume();
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
